regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares RegisterFile write port A and flags update between N requesters (core writeback, debug loader, ...).
//  Round-robin arbitration with valid/ready handshake; one write per cycle.
//  The RegisterFile writes AddrA on every Clk edge, so idle cycles issue a self-refresh: read back and rewrite one register.
//  Sits between the requesters and the RegisterFile; owns RfAddrA, RfInDataA, RfInNewFlags, RfUpdateFlags and RfAddrB.
// PARAMETERS
//  L   16  register width (matches RegisterFile l)
//  A   3   address width (matches RegisterFile a); register count R = 1<<A
//  N   2   number of requesters, 2..8
// PORTS
//  Clk            in   1     single clock, rising edge
//  RstN           in   1     synchronous reset, active-low
//  ReqValid       in   N     requester i has a write pending
//  ReqAddr        in   N*A   destination register, slice [i*A +: A]
//  ReqData        in   N*L   write data, slice [i*L +: L]
//  ReqFlagsValid  in   N     also update the flags register with ReqFlags
//  ReqFlags       in   N*L   new flags, slice [i*L +: L]
//  ReqLock        in   N     hold grant after this beat (only with RFARB_LOCK_EN)
//  ReqReady       out  N     one-hot grant; a beat transfers on Clk when ReqValid[i]&ReqReady[i]
//  RfAddrA        out  A     to RegisterFile AddrA
//  RfInDataA      out  L     to RegisterFile InDataA
//  RfInNewFlags   out  L     to RegisterFile InNewFlags
//  RfUpdateFlags  out  1     to RegisterFile UpdateFlags
//  RfAddrB        out  A     to RegisterFile AddrB (refresh readback)
//  RfDataB        in   L     from RegisterFile OutDataB
//  Busy           out  1     a grant was issued this cycle
// BEHAVIOUR
//  - Grant is combinational from ReqValid and registered state: zero-latency, write lands on the same Clk edge.
//  - Round-robin: search starts at Ptr; first valid i wins; on transfer Ptr <= i+1 mod N.
//  - Granted cycle: RfAddrA=ReqAddr[i], RfInDataA=ReqData[i]; RfUpdateFlags=ReqFlagsValid[i], RfInNewFlags=ReqFlags[i].
//  - Idle cycle (no valid): RfAddrA=RfAddrB=RefPtr, RfInDataA=RfDataB, RfUpdateFlags=0; RefPtr <= RefPtr+1, wrapping R-1 -> 0.
//  - RfAddrB=RefPtr in all cycles; granted cycles do not advance RefPtr.
//  - Flags register (R-1) is written by the register file after AddrA, so a flags update wins over a same-cycle write to R-1.
//  - ReqReady is only ever asserted with ReqValid; at most one bit is set.
//  - Requesters hold Addr/Data stable while Valid and not Ready; dropping Valid without transfer is allowed.
//  - Reset (RstN=0 at Clk): Ptr=0, RefPtr=0, state IDLE, lock cleared. While RstN=0: ReqReady=0, Busy=0, RfUpdateFlags=0, refresh path held at address 0.
//  - Reset mid-lock: lock dropped, next grant restarts at requester 0.
//  - FSM: IDLE (refresh) <-> GRANT (per-cycle arbitration); LOCKED only with RFARB_LOCK_EN.
// CONFIGURATION
//  - RFARB_LOCK_EN defined: a transfer with ReqLock[i]=1 enters LOCKED(owner=i).
//    Only i may be granted; others stall. Exit on a transfer with ReqLock=0 or on ReqValid[i]=0; Ptr <= i+1.
//    While locked and idle the owner slot refreshes.
//  - Undefined: ReqLock ignored, no LOCKED state; pure round-robin.
// STRUCTURE
//  - Package regfile_arb_pkg: state encoding (ST_IDLE, ST_GRANT, ST_LOCKED), FLAGS_ADDR = R-1 helper, rr_next function.
//  - One sub-module: rr_pick (N-wide rotate/priority-encode from Ptr, one-hot out, index out). The rest is the top-level FSM and muxes.
// TESTING
//  - Reset: RstN=0 for 2 cycles with ReqValid=2'b11 -> ReqReady=0, RfUpdateFlags=0; first post-reset grant is requester 0.
//  - Contention: N=2, both valid for 4 cycles, Addr 1/2, Data 16'hAAAA/16'h5555 -> grants 0,1,0,1; regs 1 and 2 hold last data.
//  - Idle refresh: preload r3=16'h1234, no requests for 16 cycles -> RefPtr wraps 7->0 twice, all registers unchanged.
//  - Flags: requester 1 writes Addr 7=16'h0001 with ReqFlagsValid=1, Flags=16'h0008 -> OutFlags=16'h0008.
//  - Lock (RFARB_LOCK_EN): req0 sends 3 beats with Lock=1,1,0 while req1 valid -> req1 stalls 3 cycles, then granted.
//  - Reset mid-lock: RstN=0 during LOCKED -> lock cleared, Ptr=0; req1 granted next if req0 idle.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Package: regfile_arb_pkg
// Shared definitions for the register-file write arbiter:
//   - FSM state encoding (ST_IDLE, ST_GRANT, ST_LOCKED)
//   - flags_addr(): address of the flags register (R-1) for a given address width
//   - rr_next(): round-robin successor of a requester index, modulo N
package regfile_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;  // no grant last cycle, refresh slot used
  localparam logic [1:0] ST_GRANT  = 2'd1;  // a requester was granted last cycle
  localparam logic [1:0] ST_LOCKED = 2'd2;  // grant pinned to one owner

  function automatic int flags_addr(input int a);
    return (1 << a) - 1;
  endfunction

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Interface: regfile_write_arbiter_if
// Requester-side write bus of the register-file write arbiter.
// Parameters: L (data width), A (address width), N (requesters).
//   ReqValid[N]        requester i has a write pending
//   ReqAddr[N*A]       destination register, slice [i*A +: A]
//   ReqData[N*L]       write data, slice [i*L +: L]
//   ReqFlagsValid[N]   also update the flags register
//   ReqFlags[N*L]      new flags, slice [i*L +: L]
//   ReqLock[N]         hold the grant after this beat (lock-enabled builds)
//   ReqReady[N]        one-hot grant from the arbiter
// Modports: master = requester side, slave = arbiter side.
interface regfile_write_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int L = 16,
  parameter int A = 3,
  parameter int N = 2
);

  logic [N-1:0]   ReqValid;
  logic [N*A-1:0] ReqAddr;
  logic [N*L-1:0] ReqData;
  logic [N-1:0]   ReqFlagsValid;
  logic [N*L-1:0] ReqFlags;
  logic [N-1:0]   ReqLock;
  logic [N-1:0]   ReqReady;

  modport master (
    output ReqValid, ReqAddr, ReqData, ReqFlagsValid, ReqFlags, ReqLock,
    input  ReqReady
  );

  modport slave (
    input  ReqValid, ReqAddr, ReqData, ReqFlagsValid, ReqFlags, ReqLock,
    output ReqReady
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Module: rr_pick
// Round-robin picker: searches req starting at position ptr (wrapping modulo N)
// and returns the first set bit as a one-hot grant plus its index.
// Ports:
//   req[N]   request vector
//   ptr[PW]  search start position (0..N-1)
//   gnt[N]   one-hot grant (all zero when no request)
//   idx[PW]  index of the granted requester (0 when none)
//   any      at least one request present
module rr_pick
  import regfile_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  // Walk from the farthest position back to ptr so the closest hit is the
  // last one assigned and therefore wins.
  always_comb begin
    int j;
    j   = 0;
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        idx = PW'(j);
        any = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign gnt[gi] = any && (idx == PW'(gi));
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Module: regfile_write_arbiter
// Shares RegisterFile write port A and the flags update between N requesters.
// Round-robin arbitration with a zero-latency valid/ready handshake: the grant is
// combinational and the write lands on the same Clk edge. Since the register
// file writes AddrA every edge, cycles without a grant re-write one register
// with its own value (read via port B), walking a refresh pointer over all R.
// Optional feature macro: RFARB_LOCK_EN -- a beat with ReqLock=1 pins the grant
// to that requester until a beat with ReqLock=0 or until it drops ReqValid.
// Ports:
//   Clk, RstN        clock, synchronous active-low reset
//   bus (slave)      requester handshake bus (see regfile_write_arbiter_if)
//   RfAddrA/RfInDataA/RfInNewFlags/RfUpdateFlags  to RegisterFile port A / flags
//   RfAddrB / RfDataB                             refresh readback on port B
//   Busy             a grant was issued this cycle
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int L = 16,
  parameter int A = 3,
  parameter int N = 2
) (
  input  logic                    Clk,
  input  logic                    RstN,
  regfile_write_arbiter_if.slave  bus,
  output logic [A-1:0]            RfAddrA,
  output logic [L-1:0]            RfInDataA,
  output logic [L-1:0]            RfInNewFlags,
  output logic                    RfUpdateFlags,
  output logic [A-1:0]            RfAddrB,
  input  logic [L-1:0]            RfDataB,
  output logic                    Busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_reg, ptr_next;
  logic [A-1:0]  ref_ptr_reg, ref_ptr_next;
  logic [1:0]    state_reg, state_next;

  logic [N-1:0]  pick_gnt;
  logic [PW-1:0] pick_idx;
  logic          pick_any;

  logic [PW-1:0] gnt_idx;
  logic          gnt_any;
  logic          grant;

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req (bus.ReqValid),
    .ptr (ptr_reg),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef RFARB_LOCK_EN
  logic [PW-1:0] owner_reg, owner_next;
  logic [N-1:0]  owner_hot;
  logic          locked;

  assign locked = (state_reg == ST_LOCKED);

  // While locked only the owner can be granted; everyone else stalls.
  for (genvar gi = 0; gi < N; gi++) begin : g_owner
    assign owner_hot[gi] = bus.ReqValid[gi] && (owner_reg == PW'(gi));
  end

  assign gnt_idx      = locked ? owner_reg : pick_idx;
  assign gnt_any      = locked ? bus.ReqValid[owner_reg] : pick_any;
  assign bus.ReqReady = RstN ? (locked ? owner_hot : pick_gnt) : '0;
`else
  // Pure round-robin: the state register only records grant/idle history.
  logic unused_state;
  assign unused_state = ^{state_reg, bus.ReqLock};

  assign gnt_idx      = pick_idx;
  assign gnt_any      = pick_any;
  assign bus.ReqReady = RstN ? pick_gnt : '0;
`endif

  assign grant = RstN && gnt_any;
  assign Busy  = grant;

  // Refresh readback always follows the refresh pointer; held at 0 in reset.
  assign RfAddrB = RstN ? ref_ptr_reg : '0;

  always_comb begin
    RfAddrA       = RfAddrB;
    RfInDataA     = RfDataB;
    RfInNewFlags  = '0;
    RfUpdateFlags = 1'b0;
    if (grant) begin
      RfAddrA       = bus.ReqAddr[int'(gnt_idx) * A +: A];
      RfInDataA     = bus.ReqData[int'(gnt_idx) * L +: L];
      RfInNewFlags  = bus.ReqFlags[int'(gnt_idx) * L +: L];
      RfUpdateFlags = bus.ReqFlagsValid[gnt_idx];
    end
  end

  always_comb begin
    ptr_next     = ptr_reg;
    ref_ptr_next = ref_ptr_reg;
    state_next   = ST_IDLE;
`ifdef RFARB_LOCK_EN
    owner_next   = owner_reg;
`endif
    if (grant) begin
      ptr_next   = PW'(rr_next(int'(gnt_idx), N));
      state_next = ST_GRANT;
    end else begin
      // R is a power of two, so the natural wrap gives R-1 -> 0.
      ref_ptr_next = ref_ptr_reg + A'(1);
    end
`ifdef RFARB_LOCK_EN
    if (locked) begin
      if (grant && bus.ReqLock[owner_reg]) begin
        state_next = ST_LOCKED;
      end else if (!grant) begin
        // Owner withdrew: release, and resume searching after the owner.
        ptr_next = PW'(rr_next(int'(owner_reg), N));
      end
    end else if (grant && bus.ReqLock[gnt_idx]) begin
      state_next = ST_LOCKED;
      owner_next = gnt_idx;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      ptr_reg     <= '0;
      ref_ptr_reg <= '0;
      state_reg   <= ST_IDLE;
`ifdef RFARB_LOCK_EN
      owner_reg   <= '0;
`endif
    end else begin
      ptr_reg     <= ptr_next;
      ref_ptr_reg <= ref_ptr_next;
      state_reg   <= state_next;
`ifdef RFARB_LOCK_EN
      owner_reg   <= owner_next;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench: tb_regfile_write_arbiter
// Directed checks of the register-file write arbiter (N=2, L=16, A=3) against a
// behavioural register file whose flags register (7) is written after port A.
// Lock scenarios are exercised only when RFARB_LOCK_EN is defined.
module tb_regfile_write_arbiter;

  logic        Clk = 1'b0;
  logic        RstN;
  logic [2:0]  RfAddrA, RfAddrB;
  logic [15:0] RfInDataA, RfInNewFlags, RfDataB;
  logic        RfUpdateFlags, Busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] rf [0:7];
  logic [15:0] exp_rf [0:7];

  regfile_write_arbiter_if #(.L(16), .A(3), .N(2)) bus ();

  regfile_write_arbiter #(.L(16), .A(3), .N(2)) dut (
    .Clk           (Clk),
    .RstN          (RstN),
    .bus           (bus.slave),
    .RfAddrA       (RfAddrA),
    .RfInDataA     (RfInDataA),
    .RfInNewFlags  (RfInNewFlags),
    .RfUpdateFlags (RfUpdateFlags),
    .RfAddrB       (RfAddrB),
    .RfDataB       (RfDataB),
    .Busy          (Busy)
  );

  always #5 Clk = ~Clk;

  // Register file model: port A first, flags register update takes priority.
  always @(posedge Clk) begin
    rf[RfAddrA] <= RfInDataA;
    if (RfUpdateFlags) rf[7] <= RfInNewFlags;
  end
  assign RfDataB = rf[RfAddrB];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] addr,
                         input logic [15:0] data, input logic fv,
                         input logic [15:0] flags, input logic lock);
    bus.ReqValid[i]          = v;
    bus.ReqAddr[i*3 +: 3]    = addr;
    bus.ReqData[i*16 +: 16]  = data;
    bus.ReqFlagsValid[i]     = fv;
    bus.ReqFlags[i*16 +: 16] = flags;
    bus.ReqLock[i]           = lock;
  endtask

  task automatic idle_all();
    set_req(0, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b0);
    set_req(1, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    logic [15:0] d;
    RstN = 1'b0;
    idle_all();

    // Reset with both requesters valid and asking for a flags update.
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk);
      set_req(0, 1'b1, 3'd1, 16'hAAAA, 1'b1, 16'hFFFF, 1'b0);
      set_req(1, 1'b1, 3'd2, 16'h5555, 1'b1, 16'hFFFF, 1'b0);
      #1;
      chk("rst_ready", 32'(bus.ReqReady), 32'h0);
      chk("rst_upd_flags", 32'(RfUpdateFlags), 32'h0);
      chk("rst_busy", 32'(Busy), 32'h0);
      chk("rst_addr_a", 32'(RfAddrA), 32'h0);
      chk("rst_addr_b", 32'(RfAddrB), 32'h0);
    end

    // Contention: grants alternate 0,1,0,1 starting at requester 0.
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      RstN = 1'b1;
      set_req(0, 1'b1, 3'd1, 16'hAAAA, 1'b0, 16'h0, 1'b0);
      set_req(1, 1'b1, 3'd2, 16'h5555, 1'b0, 16'h0, 1'b0);
      #1;
      chk("cont_ready", 32'(bus.ReqReady), (c % 2 == 0) ? 32'h1 : 32'h2);
      chk("cont_addr_a", 32'(RfAddrA), (c % 2 == 0) ? 32'h1 : 32'h2);
      chk("cont_data_a", 32'(RfInDataA), (c % 2 == 0) ? 32'hAAAA : 32'h5555);
      chk("cont_busy", 32'(Busy), 32'h1);
    end
    @(negedge Clk);
    idle_all();
    set_req(0, 1'b1, 3'd0, 16'h1000, 1'b0, 16'h0, 1'b0);
    #1;
    chk("cont_r1", 32'(rf[1]), 32'hAAAA);
    chk("cont_r2", 32'(rf[2]), 32'h5555);
    chk("pre_ready", 32'(bus.ReqReady), 32'h1);

    // Preload remaining registers through requester 0 (r0 already on the bus).
    for (int k = 3; k < 8; k++) begin
      @(negedge Clk);
      d = (k == 3) ? 16'h1234 : 16'h1000 + 16'(k);
      set_req(0, 1'b1, 3'(k), d, 1'b0, 16'h0, 1'b0);
      #1;
      chk("pre_ready", 32'(bus.ReqReady), 32'h1);
      chk("pre_addr_a", 32'(RfAddrA), 32'(k));
    end

    // Idle refresh: 16 cycles, pointer wraps 7 -> 0 twice.
    for (int k = 0; k < 16; k++) begin
      @(negedge Clk);
      idle_all();
      #1;
      chk("ref_addr_b", 32'(RfAddrB), 32'(k % 8));
      chk("ref_addr_a", 32'(RfAddrA), 32'(k % 8));
      chk("ref_busy", 32'(Busy), 32'h0);
    end
    exp_rf[0] = 16'h1000; exp_rf[1] = 16'hAAAA; exp_rf[2] = 16'h5555; exp_rf[3] = 16'h1234;
    exp_rf[4] = 16'h1004; exp_rf[5] = 16'h1005; exp_rf[6] = 16'h1006; exp_rf[7] = 16'h1007;
    @(negedge Clk);
    #1;
    for (int k = 0; k < 8; k++) chk($sformatf("ref_r%0d", k), 32'(rf[k]), 32'(exp_rf[k]));

    // Flags: requester 1 writes r7 and a flags update in the same cycle.
    @(negedge Clk);
    set_req(1, 1'b1, 3'd7, 16'h0001, 1'b1, 16'h0008, 1'b0);
    #1;
    chk("flg_ready", 32'(bus.ReqReady), 32'h2);
    chk("flg_upd", 32'(RfUpdateFlags), 32'h1);
    chk("flg_new", 32'(RfInNewFlags), 32'h0008);
    @(negedge Clk);
    idle_all();
    set_req(0, 1'b1, 3'd5, 16'h5A5A, 1'b1, 16'h0020, 1'b0);
    #1;
    chk("flg_r7_wins", 32'(rf[7]), 32'h0008);
    chk("flg_ready0", 32'(bus.ReqReady), 32'h1);
    @(negedge Clk);
    idle_all();
    #1;
    chk("flg_r5", 32'(rf[5]), 32'h5A5A);
    chk("flg_r7", 32'(rf[7]), 32'h0020);
    chk("flg_idle_upd", 32'(RfUpdateFlags), 32'h0);

    // Reset with Ptr=1: first grant afterwards goes back to requester 0.
    @(negedge Clk);
    RstN = 1'b0;
    set_req(0, 1'b1, 3'd1, 16'h1111, 1'b0, 16'h0, 1'b0);
    set_req(1, 1'b1, 3'd2, 16'h2222, 1'b0, 16'h0, 1'b0);
    #1;
    chk("rst2_ready", 32'(bus.ReqReady), 32'h0);
    @(negedge Clk);
    RstN = 1'b1;
    #1;
    chk("rst2_first", 32'(bus.ReqReady), 32'h1);
    @(negedge Clk);
    set_req(0, 1'b0, 3'd1, 16'h1111, 1'b0, 16'h0, 1'b0);
    #1;
    chk("solo1_ready", 32'(bus.ReqReady), 32'h2);

`ifdef RFARB_LOCK_EN
    // Lock: req0 three beats (lock 1,1,0) while req1 waits.
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      set_req(0, 1'b1, 3'd4, 16'h4440 + 16'(c), 1'b0, 16'h0, (c < 2) ? 1'b1 : 1'b0);
      set_req(1, 1'b1, 3'd6, 16'h6666, 1'b0, 16'h0, 1'b0);
      #1;
      chk("lock_ready", 32'(bus.ReqReady), 32'h1);
    end
    @(negedge Clk);
    set_req(0, 1'b0, 3'd4, 16'h0, 1'b0, 16'h0, 1'b0);
    #1;
    chk("lock_release", 32'(bus.ReqReady), 32'h2);

    // Reset mid-lock.
    @(negedge Clk);
    set_req(0, 1'b1, 3'd4, 16'h4444, 1'b0, 16'h0, 1'b1);
    #1;
    chk("rlock_enter", 32'(bus.ReqReady), 32'h1);
    @(negedge Clk);
    RstN = 1'b0;
    #1;
    chk("rlock_rst", 32'(bus.ReqReady), 32'h0);
    @(negedge Clk);
    RstN = 1'b1;
    set_req(0, 1'b0, 3'd4, 16'h0, 1'b0, 16'h0, 1'b0);
    #1;
    chk("rlock_req1", 32'(bus.ReqReady), 32'h2);
`endif

    @(negedge Clk);
    idle_all();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
